// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and baud constants.
`default_nettype none

package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // 50 MHz / (16 * 115200), rounded
  localparam int BAUD_DVSR_115200 = 27;
  localparam int OVERSAMPLE       = 16;

endpackage

`default_nettype wire

// File: rtl/uart_rx_baud_gen.sv
// baud_gen: free-running mod-M counter producing a one-clk oversample tick.
`default_nettype none

module baud_gen #(
  parameter int M = 27,
  parameter int N = 5
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [N-1:0] C_LAST = N'(M - 1);

  logic [N-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (count == C_LAST) begin
      count <= '0;
    end else begin
      count <= count + N'(1);
    end
  end

  assign tick = (count == C_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with glitch rejection and framing-error flag.
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = OVERSAMPLE,
  parameter int DVSR    = BAUD_DVSR_115200,
  parameter int DVSR_W  = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
);

  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] C_S_MID       = SW'(7);
  localparam logic [SW-1:0] C_S_DATA_LAST = SW'(15);
  localparam logic [SW-1:0] C_S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] C_N_LAST      = NW'(DBIT - 1);

  logic            tick;
  logic            sync_q1;
  logic            rx_s;
  logic [1:0]      state_reg, state_next;
  logic [SW-1:0]   s_reg, s_next;
  logic [NW-1:0]   n_reg, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic [DBIT-1:0] dout_reg, dout_next;
  logic            done_reg, done_next;
  logic            ferr_reg, ferr_next;
  logic            stop_exit;

  baud_gen #(
    .M (DVSR),
    .N (DVSR_W)
  ) u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Synchronizer resets to the idle line level so reset release never looks like a start edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync_q1 <= rx;
      rx_s    <= sync_q1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      s_reg     <= '0;
      n_reg     <= '0;
      b_reg     <= '0;
      dout_reg  <= '0;
      done_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      n_reg     <= n_next;
      b_reg     <= b_next;
      dout_reg  <= dout_next;
      done_reg  <= done_next;
      ferr_reg  <= ferr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    b_next     = b_reg;
    case (state_reg)
      ST_IDLE: begin
        // Falling edge is taken on any clk, not just on a tick
        if (!rx_s) begin
          state_next = ST_START;
          s_next     = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (s_reg == C_S_MID) begin
            if (!rx_s) begin
              state_next = ST_DATA;
              s_next     = '0;
              n_next     = '0;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (s_reg == C_S_DATA_LAST) begin
            s_next = '0;
            b_next = {rx_s, b_reg[DBIT-1:1]};
            if (n_reg == C_N_LAST) begin
              state_next = ST_STOP;
            end else begin
              n_next = n_reg + NW'(1);
            end
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
      default: begin
        if (tick) begin
          if (s_reg == C_S_STOP_LAST) begin
            state_next = ST_IDLE;
          end else begin
            s_next = s_reg + SW'(1);
          end
        end
      end
    endcase
  end

  always_comb begin
    stop_exit = (state_reg == ST_STOP) && tick && (s_reg == C_S_STOP_LAST);
    done_next = stop_exit && rx_s;
    ferr_next = stop_exit && !rx_s;
    dout_next = stop_exit ? b_reg : dout_reg;
  end

  assign dout         = dout_reg;
  assign rx_done_tick = done_reg;
  assign frame_err    = ferr_reg;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames, glitch, framing error, mid-frame reset and jittered random bytes.
`default_nettype none

module tb_uart_rx;
  import uart_pkg::*;

  localparam int BIT_CLK = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  int last_jit = 0;
  logic [7:0] rx_log[$];
  logic [7:0] exp_q[$];

  uart_rx #(
    .DBIT    (8),
    .SB_TICK (16),
    .DVSR    (2),
    .DVSR_W  (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_done_tick) begin
      done_cnt++;
      rx_log.push_back(dout);
    end
    if (frame_err) ferr_cnt++;
    if (rx_done_tick && frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) hold(d[i], BIT_CLK);
    hold(stop, BIT_CLK);
  endtask

  // Each bit edge moves by up to +/-2 clk from its nominal position
  task automatic send_jit(input logic [7:0] d);
    logic [9:0] bits;
    int j;
    bits = {1'b1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      j = int'($urandom_range(4, 0)) - 2;
      hold(bits[i], BIT_CLK + j - last_jit);
      last_jit = j;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    int f0;
    int base;
    logic [7:0] rb;

    rx = 1'b1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_dout", 32'(dout), 32'h00);
    check("reset_done", 32'(rx_done_tick), 32'h0);
    check("reset_ferr", 32'(frame_err), 32'h0);
    check("reset_state", 32'(dut.state_reg), 32'(ST_IDLE));
    reset = 1'b1;
    hold(1'b1, 20);

    d0 = done_cnt;
    send_frame(8'h55, 1'b1);
    hold(1'b1, 10);
    check("f55_pulses", 32'(done_cnt - d0), 32'd1);
    check("f55_dout", 32'(dout), 32'h55);
    check("f55_ferr", 32'(ferr_cnt), 32'd0);

    base = rx_log.size();
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    hold(1'b1, 10);
    check("b2b_pulses", 32'(rx_log.size() - base), 32'd2);
    if (rx_log.size() >= base + 2) begin
      check("b2b_first", 32'(rx_log[base]), 32'hA3);
      check("b2b_second", 32'(rx_log[base+1]), 32'h0F);
    end

    d0 = done_cnt;
    f0 = ferr_cnt;
    hold(1'b0, 12);
    hold(1'b1, 40);
    check("glitch_state", 32'(dut.state_reg), 32'(ST_IDLE));
    check("glitch_done", 32'(done_cnt - d0), 32'd0);
    check("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("glitch_dout", 32'(dout), 32'h0F);

    d0 = done_cnt;
    f0 = ferr_cnt;
    rb = 8'h3C;
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) hold(rb[i], BIT_CLK);
    hold(1'b0, 26);
    check("ferr_reenter", 32'(dut.state_reg), 32'(ST_START));
    hold(1'b1, 40);
    check("ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
    check("ferr_done", 32'(done_cnt - d0), 32'd0);
    check("ferr_dout", 32'(dout), 32'h3C);
    check("ferr_idle", 32'(dut.state_reg), 32'(ST_IDLE));

    d0 = done_cnt;
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) hold(1'b1, BIT_CLK);
    hold(1'b1, 16);
    reset = 1'b0;
    hold(1'b1, 4);
    check("rst_dout", 32'(dout), 32'h00);
    check("rst_state", 32'(dut.state_reg), 32'(ST_IDLE));
    reset = 1'b1;
    hold(1'b1, 16 + 4 * BIT_CLK);
    send_frame(8'h81, 1'b1);
    hold(1'b1, 10);
    check("rst_pulses", 32'(done_cnt - d0), 32'd1);
    check("rst_dout81", 32'(dout), 32'h81);

    base = rx_log.size();
    f0 = ferr_cnt;
    last_jit = 0;
    for (int k = 0; k < 256; k++) begin
      rb = 8'($urandom);
      exp_q.push_back(rb);
      send_jit(rb);
    end
    hold(1'b1, 20);
    check("rand_count", 32'(rx_log.size() - base), 32'd256);
    check("rand_ferr", 32'(ferr_cnt - f0), 32'd0);
    for (int k = 0; k < 256; k++) begin
      if (base + k < rx_log.size()) check($sformatf("rand_byte%0d", k), 32'(rx_log[base+k]), 32'(exp_q[k]));
    end

    check("never_both", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
